ir_byte_sender: RTL and testbench

Transmit side of the 8-bit instruction load bus: accepts 16-bit instruction words from a fetch source over a valid/ready handshake and buffers them in a small FIFO. It drives each word onto `data[7:0]` as two consecutive byte beats, high byte first, with `ena` held high across both beats. The output matches the two-beat, high-then-low load protocol of the instruction register, so `data`/`ena` connect directly to the register's `data`/`ena` inputs. It sits between the program memory fetch path and the instruction register, on the same `clk1` domain.

---
 rtl/ir_bus_pkg.sv | 6 +
 rtl/ir_byte_sender_if.sv | 15 +
 rtl/word_fifo.sv | 35 +++
 rtl/ir_byte_sender.sv | 66 ++++++
 tb/tb_ir_byte_sender.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/ir_bus_pkg.sv
// ir_bus_pkg: widths and FSM states shared by the instruction load bus sender
package ir_bus_pkg;
    localparam int BYTE_W = 8;
    localparam int WORD_W = 16;
    typedef enum logic [1:0] {IDLE = 2'd0, HI = 2'd1, LO = 2'd2} state_t;
endpackage

// File: rtl/ir_byte_sender_if.sv
// ir_byte_sender_if: fetch-side word handshake plus byte load bus of the sender
interface ir_byte_sender_if;
    import ir_bus_pkg::*;
    logic [WORD_W-1:0] in_word;
    logic              in_valid;
    logic              in_ready;
    logic              hold;
    logic [BYTE_W-1:0] data;
    logic              ena;
    logic              word_done;
    logic              busy;
    logic [WORD_W-1:0] words_sent;
    modport master (output in_word, in_valid, hold, input in_ready, data, ena, word_done, busy, words_sent);
    modport slave (input in_word, in_valid, hold, output in_ready, data, ena, word_done, busy, words_sent);
endinterface

// File: rtl/word_fifo.sv
// word_fifo: power-of-two FIFO using pointers with an extra wrap bit
module word_fifo #(
    parameter int DEPTH = 2,
    parameter int W = 16
) (
    input  logic                   clk1,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           wdata,
    output logic [W-1:0]           rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW:0] wptr, rptr;
    always_ff @(posedge clk1) begin
        if (push && !full) mem[wptr[AW-1:0]] <= wdata;
    end
    always_ff @(posedge clk1) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push && !full) wptr <= wptr + 1'b1;
            if (pop && !empty) rptr <= rptr + 1'b1;
        end
    end
    assign rdata = mem[rptr[AW-1:0]];
    assign empty = wptr == rptr;
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign count = wptr - rptr;
endmodule

// File: rtl/ir_byte_sender.sv
// ir_byte_sender: buffers 16-bit words and sends each as a high-then-low byte pair
module ir_byte_sender
    import ir_bus_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input logic clk1,
    input logic rst,
    ir_byte_sender_if.slave bus
);
    state_t state;
    logic [WORD_W-1:0] head;
    logic [BYTE_W-1:0] lo_byte;
    logic [WORD_W-1:0] sent;
    logic [$clog2(DEPTH):0] count;
    logic full, empty, pop;
    assign bus.in_ready   = !full && !rst;
    // pops only happen at word boundaries, so a word is never split by hold
    assign pop            = (state == IDLE || state == LO) && !empty && !bus.hold;
    assign bus.busy       = state != IDLE || count != '0;
    assign bus.words_sent = sent;
    word_fifo #(.DEPTH(DEPTH), .W(WORD_W)) u_fifo (
        .clk1  (clk1),
        .rst   (rst),
        .push  (bus.in_valid && bus.in_ready),
        .pop   (pop),
        .wdata (bus.in_word),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );
    always_ff @(posedge clk1) begin
        if (rst) begin
            state         <= IDLE;
            bus.data      <= '0;
            bus.ena       <= 1'b0;
            bus.word_done <= 1'b0;
            sent          <= '0;
            lo_byte       <= '0;
        end else begin
            case (state)
                IDLE, LO: begin
                    bus.word_done <= 1'b0;
                    bus.data      <= pop ? head[WORD_W-1:BYTE_W] : '0;
                    bus.ena       <= pop;
                    lo_byte       <= head[BYTE_W-1:0];
                    state         <= pop ? HI : IDLE;
                end
                HI: begin
                    bus.data      <= lo_byte;
                    bus.ena       <= 1'b1;
                    bus.word_done <= 1'b1;
                    sent          <= sent + 1'b1;
                    state         <= LO;
                end
                default: begin
                    bus.data      <= '0;
                    bus.ena       <= 1'b0;
                    bus.word_done <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ir_byte_sender.sv
// tb_ir_byte_sender: directed scenarios for the byte sender with hand-computed expectations
module tb_ir_byte_sender;
    logic clk1 = 1'b0;
    logic rst = 1'b1;
    int tests = 0;
    int fails = 0;
    logic [7:0] got[$];
    int run, max_run;

    ir_byte_sender_if ifc();
    ir_byte_sender #(.DEPTH(2)) dut (.clk1(clk1), .rst(rst), .bus(ifc.slave));

    always #5 clk1 = ~clk1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk1);
        #1;
    endtask

    task automatic clear_log();
        got.delete();
        run = 0;
        max_run = 0;
    endtask

    task automatic sample();
        if (ifc.ena === 1'b1) begin
            got.push_back(ifc.data);
            run++;
            if (run > max_run) max_run = run;
        end else run = 0;
    endtask

    task automatic collect(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            sample();
        end
    endtask

    task automatic test_reset();
        ifc.in_valid = 0; ifc.in_word = '0; ifc.hold = 0; rst = 1;
        step(); step();
        tests++; if (ifc.in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready: got %b expected 0", ifc.in_ready); end
        tests++; if (ifc.ena !== 1'b0 || ifc.data !== 8'h00) begin fails++; $display("FAIL reset_bus: got ena=%b data=%h expected 0/00", ifc.ena, ifc.data); end
        rst = 0;
        step();
        tests++; if (ifc.in_ready !== 1'b1) begin fails++; $display("FAIL post_reset_in_ready: got %b expected 1", ifc.in_ready); end
        tests++; if (ifc.busy !== 1'b0 || ifc.word_done !== 1'b0 || ifc.words_sent !== 16'd0) begin fails++; $display("FAIL reset_status: got busy=%b wd=%b sent=%h expected 0/0/0000", ifc.busy, ifc.word_done, ifc.words_sent); end
    endtask

    task automatic test_single();
        ifc.in_word = 16'hA55A; ifc.in_valid = 1;
        step();
        ifc.in_valid = 0;
        tests++; if (ifc.ena !== 1'b0 || ifc.busy !== 1'b1) begin fails++; $display("FAIL single_e0: got ena=%b busy=%b expected 0/1", ifc.ena, ifc.busy); end
        step();
        tests++; if (ifc.ena !== 1'b1 || ifc.data !== 8'hA5 || ifc.word_done !== 1'b0) begin fails++; $display("FAIL single_e1: got ena=%b data=%h wd=%b expected 1/A5/0", ifc.ena, ifc.data, ifc.word_done); end
        step();
        tests++; if (ifc.ena !== 1'b1 || ifc.data !== 8'h5A || ifc.word_done !== 1'b1) begin fails++; $display("FAIL single_e2: got ena=%b data=%h wd=%b expected 1/5A/1", ifc.ena, ifc.data, ifc.word_done); end
        tests++; if (ifc.words_sent !== 16'd1) begin fails++; $display("FAIL single_count: got %h expected 0001", ifc.words_sent); end
        step();
        tests++; if (ifc.ena !== 1'b0 || ifc.data !== 8'h00 || ifc.word_done !== 1'b0 || ifc.busy !== 1'b0) begin fails++; $display("FAIL single_e3: got ena=%b data=%h wd=%b busy=%b expected 0/00/0/0", ifc.ena, ifc.data, ifc.word_done, ifc.busy); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] words[3] = '{16'h1234, 16'h5678, 16'h9ABC};
        logic [7:0] exp[6] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
        int idx = 0;
        logic pushed;
        clear_log();
        for (int c = 0; c < 10; c++) begin
            ifc.in_valid = idx < 3;
            ifc.in_word = idx < 3 ? words[idx] : 16'h0000;
            pushed = ifc.in_valid && ifc.in_ready;
            step();
            if (pushed) idx++;
            sample();
            if (c == 2) begin
                tests++; if (ifc.in_ready !== 1'b0) begin fails++; $display("FAIL b2b_in_ready_drop: got %b expected 0", ifc.in_ready); end
            end
        end
        ifc.in_valid = 0;
        tests++; if (got.size() != 6 || max_run != 6) begin fails++; $display("FAIL b2b_ena_run: got beats=%0d run=%0d expected 6/6", got.size(), max_run); end
        for (int i = 0; i < 6; i++) begin
            tests++; if (got[i] !== exp[i]) begin fails++; $display("FAIL b2b_byte%0d: got %h expected %h", i, got[i], exp[i]); end
        end
        tests++; if (ifc.words_sent !== 16'd4) begin fails++; $display("FAIL b2b_count: got %h expected 0004", ifc.words_sent); end
    endtask

    task automatic test_hold_hi();
        ifc.in_word = 16'hDEAD; ifc.in_valid = 1;
        step();
        ifc.in_word = 16'hBEEF;
        step();
        ifc.in_valid = 0;
        tests++; if (ifc.ena !== 1'b1 || ifc.data !== 8'hDE) begin fails++; $display("FAIL hold_hi_byte: got ena=%b data=%h expected 1/DE", ifc.ena, ifc.data); end
        ifc.hold = 1;
        step();
        tests++; if (ifc.ena !== 1'b1 || ifc.data !== 8'hAD) begin fails++; $display("FAIL hold_lo_byte: got ena=%b data=%h expected 1/AD", ifc.ena, ifc.data); end
        for (int i = 0; i < 4; i++) begin
            step();
            tests++; if (ifc.ena !== 1'b0 || ifc.data !== 8'h00 || ifc.busy !== 1'b1) begin fails++; $display("FAIL hold_idle%0d: got ena=%b data=%h busy=%b expected 0/00/1", i, ifc.ena, ifc.data, ifc.busy); end
        end
        ifc.hold = 0;
        step();
        tests++; if (ifc.ena !== 1'b1 || ifc.data !== 8'hBE) begin fails++; $display("FAIL hold_release_hi: got ena=%b data=%h expected 1/BE", ifc.ena, ifc.data); end
        step();
        tests++; if (ifc.ena !== 1'b1 || ifc.data !== 8'hEF) begin fails++; $display("FAIL hold_release_lo: got ena=%b data=%h expected 1/EF", ifc.ena, ifc.data); end
        step();
        tests++; if (ifc.ena !== 1'b0 || ifc.words_sent !== 16'd6) begin fails++; $display("FAIL hold_end: got ena=%b sent=%h expected 0/0006", ifc.ena, ifc.words_sent); end
    endtask

    task automatic test_full();
        logic [7:0] exp[6] = '{8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33};
        ifc.hold = 1; ifc.in_valid = 1; ifc.in_word = 16'h1111;
        step();
        ifc.in_word = 16'h2222;
        step();
        ifc.in_word = 16'h3333;
        for (int i = 0; i < 3; i++) begin
            tests++; if (ifc.in_ready !== 1'b0 || ifc.ena !== 1'b0) begin fails++; $display("FAIL full_stall%0d: got ready=%b ena=%b expected 0/0", i, ifc.in_ready, ifc.ena); end
            step();
        end
        ifc.hold = 0;
        step();
        tests++; if (ifc.in_ready !== 1'b1 || ifc.data !== 8'h11) begin fails++; $display("FAIL full_reopen: got ready=%b data=%h expected 1/11", ifc.in_ready, ifc.data); end
        clear_log();
        sample();
        step();
        ifc.in_valid = 0;
        tests++; if (ifc.in_ready !== 1'b0) begin fails++; $display("FAIL full_accept: got ready=%b expected 0", ifc.in_ready); end
        sample();
        collect(7);
        tests++; if (got.size() != 6 || max_run != 6) begin fails++; $display("FAIL full_ena_run: got beats=%0d run=%0d expected 6/6", got.size(), max_run); end
        for (int i = 0; i < 6; i++) begin
            tests++; if (got[i] !== exp[i]) begin fails++; $display("FAIL full_byte%0d: got %h expected %h", i, got[i], exp[i]); end
        end
        tests++; if (ifc.words_sent !== 16'd9) begin fails++; $display("FAIL full_count: got %h expected 0009", ifc.words_sent); end
    endtask

    task automatic test_reset_mid();
        ifc.in_word = 16'hC33C; ifc.in_valid = 1;
        step();
        ifc.in_valid = 0;
        step();
        tests++; if (ifc.ena !== 1'b1 || ifc.data !== 8'hC3) begin fails++; $display("FAIL rstmid_hi: got ena=%b data=%h expected 1/C3", ifc.ena, ifc.data); end
        rst = 1;
        step();
        tests++; if (ifc.ena !== 1'b0 || ifc.data !== 8'h00 || ifc.busy !== 1'b0 || ifc.words_sent !== 16'd0) begin fails++; $display("FAIL rstmid_after: got ena=%b data=%h busy=%b sent=%h expected 0/00/0/0000", ifc.ena, ifc.data, ifc.busy, ifc.words_sent); end
        rst = 0;
        clear_log();
        collect(5);
        tests++; if (got.size() != 0 || ifc.busy !== 1'b0) begin fails++; $display("FAIL rstmid_no_low: got beats=%0d busy=%b expected 0/0", got.size(), ifc.busy); end
    endtask

    task automatic test_wrap();
        force dut.sent = 16'hFFFF;
        #1;
        release dut.sent;
        tests++; if (ifc.words_sent !== 16'hFFFF) begin fails++; $display("FAIL wrap_preload: got %h expected FFFF", ifc.words_sent); end
        ifc.in_word = 16'h0F0F; ifc.in_valid = 1;
        step();
        ifc.in_valid = 0;
        clear_log();
        collect(4);
        tests++; if (ifc.words_sent !== 16'h0000) begin fails++; $display("FAIL wrap_count: got %h expected 0000", ifc.words_sent); end
        tests++; if (got.size() != 2 || got[0] !== 8'h0F || got[1] !== 8'h0F) begin fails++; $display("FAIL wrap_bytes: got beats=%0d expected 2 of 0F", got.size()); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_hold_hi();
        test_full();
        test_reset_mid();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
